// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals around the UART TX arbiter.
// master is the client/transmitter side, slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int GW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [GW-1:0]            grant_id;
    logic                     owner_valid;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_data_en;
    logic                     tx_busy;
    logic                     err_timeout;
    modport master (
        output req, req_lock, req_data, tx_busy,
        input  ack, grant_id, owner_valid, tx_data, tx_data_en, err_timeout
    );
    modport slave (
        input  req, req_lock, req_data, tx_busy,
        output ack, grant_id, owner_valid, tx_data, tx_data_en, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, with per-requester frame lock.
// Launches one byte per grant and sequences on the transmitter's tx_busy flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input logic clk,
    input logic rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d, gid_q, gid_d, rr_win, idx;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              lock_q, lock_d, err;
    // Descending search so the requester closest after the pointer is assigned last and wins.
    always_comb begin
        rr_win = ptr_q;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = GW'((int'(ptr_q) + i) % NUM_REQ);
            if (bus.req[idx]) rr_win = idx;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        gid_d = gid_q;
        data_d = data_q;
        lock_d = lock_q;
        cnt_d = cnt_q;
        err = 1'b0;
        case (state_q)
            IDLE: if (!bus.tx_busy && |bus.req) begin
                gid_d = (lock_q && bus.req[gid_q]) ? gid_q : rr_win;
                ptr_d = gid_d;
                data_d = bus.req_data[gid_d*WIDTH +: WIDTH];
                state_d = LAUNCH;
            end
            LAUNCH: begin
                lock_d = bus.req_lock[gid_q];
                cnt_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (bus.tx_busy) begin
                state_d = WAIT_DONE;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                err = 1'b1;
                lock_d = 1'b0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= GW'(NUM_REQ - 1);
            gid_q <= '0;
            data_q <= '0;
            lock_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            gid_q <= gid_d;
            data_q <= data_d;
            lock_q <= lock_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.tx_data_en = state_q == LAUNCH;
    assign bus.ack = {{(NUM_REQ-1){1'b0}}, bus.tx_data_en} << gid_q;
    assign bus.grant_id = gid_q;
    assign bus.tx_data = data_q;
    assign bus.owner_valid = state_q != IDLE || lock_q;
    assign bus.err_timeout = err;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ independent requesters.
- Arbitrates byte requests round-robin, with optional per-requester lock for multi-byte frames.
- Drives the transmitter's data/data_en strobe and sequences on its tx_busy flag.
- Sits between client logic (command responders, log streamers) and the uart_tx instance.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 8: byte width, matches the transmitter data width.
- BUSY_TIMEOUT, 16: cycles to wait for tx_busy to rise after a strobe before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester byte request; hold high until ack.
- req_lock  in  NUM_REQ  per-requester frame lock; high means "more bytes follow, keep ownership".
- req_data  in  NUM_REQ*WIDTH  packed bytes; requester i occupies bits [i*WIDTH +: WIDTH].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last owner.
- owner_valid  out  1  high while a byte is in flight or a lock is held.
- tx_data  out  WIDTH  byte to the transmitter.
- tx_data_en  out  1  one-cycle launch strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- err_timeout  out  1  one-cycle pulse: tx_busy never rose after a strobe.

Behaviour:
- Reset (rst=0, async):
  - ack, tx_data, tx_data_en, owner_valid, err_timeout, grant_id all go to 0.
  - Lock is cleared, FSM goes to IDLE.
  - RR pointer goes to NUM_REQ-1, so requester 0 wins first.
  - Asserting reset mid-byte aborts immediately; the transmitter is reset separately.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Acts only when tx_busy=0 and req is non-zero.
  - Winner selection:
    - If a lock is held and the lock owner's req=1, the lock owner wins.
    - If a lock is held and the lock owner's req=0, the lock is released and normal round-robin applies the same cycle.
    - Round-robin searches from pointer+1 upward, wrapping modulo NUM_REQ.
  - On a win: register req_data slice into tx_data, set grant_id, update pointer to the winner, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - tx_data_en=1 and ack[grant_id]=1 in the same cycle.
  - Lock flag := req_lock[grant_id].
  - Go to WAIT_BUSY.
  - Latency from req sampled in IDLE to strobe: 1 cycle.
- WAIT_BUSY:
  - Go to WAIT_DONE when tx_busy=1.
  - If BUSY_TIMEOUT cycles elapse without tx_busy: pulse err_timeout, clear lock, go to IDLE.
- WAIT_DONE:
  - Go to IDLE when tx_busy=0.
  - Next grant is possible in the IDLE cycle after that.
- req is ignored outside IDLE. Requesters must drop req or present a new byte in the cycle after ack; a req still high on re-entry to IDLE is a new byte.
- tx_data holds its value until the next grant.
- owner_valid = (state != IDLE) or lock held.
- Simultaneous requests go strictly round-robin; a lock overrides round-robin only for its holder.
- Boundaries:
  - Lock holder asserting req with req_lock=0 sends its final byte, then the lock is released.
  - NUM_REQ wrap: after requester NUM_REQ-1, the search continues at 0.

Test Plan:
- Single requester 0 sends 8'h42 with model tx: tx_data_en pulses 1 cycle after req with tx_data=8'h42; ack[0] in the same cycle; grant_id=0; idle between bytes.
- Requesters 1 and 2 request simultaneously after reset, bytes 8'h11 and 8'h22: order 1 then 2; second strobe only after tx_busy falls; each ack pulses exactly once.
- All four request continuously: grant sequence 0,1,2,3,0,1; no requester starves.
- Requester 2 holds req_lock=1 for 3 bytes 8'hA0..8'hA2 while requester 0 requests: three consecutive grants to 2, then 0 is granted after the third byte (req_lock=0).
- tx_busy tied 0: err_timeout pulses exactly BUSY_TIMEOUT=16 cycles after the strobe; FSM returns to IDLE and re-serves the pending req.
- rst asserted during WAIT_DONE: all outputs read 0 on the same edge; after release, requester 0 wins first despite an earlier pointer value.
